// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB first through
// an external single-bit full-adder cell, one bit per clock, and collects the
// sum bits into a result register with a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_msb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // The bit being processed this cycle is the final one when the counter
  // has reached WIDTH-1.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Place the fresh sum bit at the MSB; written this way so WIDTH=1 works.
  always_comb begin
    sum_msb            = '0;
    sum_msb[WIDTH-1]   = fa_sum;
  end

  // Next-state decode plus Moore outputs; the adder cell sees zeros unless RUN.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sh[0];
        fa_b   = b_sh[0];
        fa_cin = carry;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath: capture on accepted start, shift while RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin_init;
            cnt   <= '0;
          end
        end
        RUN: begin
          result <= (result >> 1) | sum_msb;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (last_bit) carry_out <= fa_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases plus 1000 random additions,
// checked against plain integer addition of the captured operands.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  // WIDTH=8 instance
  logic       start;
  logic [7:0] op_a, op_b;
  logic       cin_init;
  logic       busy, done, carry_out;
  logic [7:0] result;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  // WIDTH=1 instance
  logic       start1;
  logic [0:0] op_a1, op_b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] result1;
  logic       fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_cout;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  // Full-adder cells sitting beside each sequencer
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
  assign fa1_sum  = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_cout = (fa1_a & fa1_b) | (fa1_cin & (fa1_a ^ fa1_b));

  serial_add_ctrl #(.WIDTH(8), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .cin_init(cin_init), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  serial_add_ctrl #(.WIDTH(1), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .cin_init(cin1), .busy(busy1), .done(done1), .result(result1),
    .carry_out(cout1), .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin),
    .fa_sum(fa1_sum), .fa_cout(fa1_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation on the 8-bit instance, starting and ending at a
  // falling edge with the sequencer idle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] exp;
    int busy_cnt;
    int waited;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    chk("fa_idle_before", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    start = 1'b1; op_a = a; op_b = b; cin_init = ci;
    @(negedge clk);
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); cin_init = 1'($urandom);
    busy_cnt = 0;
    waited   = 0;
    while (!done && waited < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    if (busy && done) overlap++;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_len", busy_cnt, 8);
    chk("result", {24'd0, result}, {24'd0, exp[7:0]});
    chk("carry_out", {31'd0, carry_out}, {31'd0, exp[8]});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("fa_idle_done", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ha [0:40];
    logic [7:0] hb [0:40];
    logic       hc [0:40];
    int         dtimes[$];
    logic [8:0] e;
    int         k;
    int         seen;
    int         bcnt;
    int         waited;

    // Reset, with start asserted to show reset wins
    rst = 1'b1; start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin_init = 1'b1;
    start1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; start1 = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed additions
    do_op(8'h3C, 8'h5A, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);

    // start held high: captures only in IDLE, one op every WIDTH+2 cycles
    for (int cyc = 0; cyc <= 34; cyc++) begin
      if (done) begin
        dtimes.push_back(cyc);
        k = cyc - 9;
        if (k >= 0) begin
          e = {1'b0, ha[k]} + {1'b0, hb[k]} + {8'd0, hc[k]};
          chk("held_result", {23'd0, carry_out, result}, {23'd0, e});
        end else begin
          chk("held_early_done", cyc, 9);
        end
      end
      start    = (cyc < 30);
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      cin_init = 1'($urandom);
      ha[cyc]  = op_a;
      hb[cyc]  = op_b;
      hc[cyc]  = cin_init;
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_done_count", dtimes.size(), 3);
    for (int i = 0; i < dtimes.size(); i++) chk("held_done_time", dtimes[i], 9 + 10 * i);

    // Reset in the 4th RUN cycle aborts the operation
    start = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin_init = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_carry", {31'd0, carry_out}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    do_op(8'h01, 8'h01, 1'b0);

    // WIDTH=1 instance: 1+1+1
    start1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; op_a1 = 1'b0; op_b1 = 1'b0; cin1 = 1'b0;
    bcnt = 0; waited = 0;
    while (!done1 && waited < 10) begin
      if (busy1) bcnt++;
      @(negedge clk);
      waited++;
    end
    chk("w1_done", {31'd0, done1}, 32'd1);
    chk("w1_busy_len", bcnt, 1);
    chk("w1_result", {31'd0, result1}, 32'd1);
    chk("w1_carry", {31'd0, cout1}, 32'd1);
    @(negedge clk);

    // Random operations
    for (int n = 0; n < 1000; n++) do_op(8'($urandom), 8'($urandom), 1'($urandom));
    chk("done_busy_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
